mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between the core's instruction-fetch requester and its data (load/store) requester.
- Replaces the dual-port ram coupling for the multicycle/pipelined core variants.
- Grants at most one request per cycle with round-robin priority.
- Returns read data one cycle after the grant, tagged to the requester that owns it.
- Requesters stall while their ready is low.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/rr_arbiter2.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 82 ++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter and its round-robin core.
package mem_arb_pkg;

    localparam int WORD_BITS = 32;

    // Owner of the read response returning from the RAM this cycle.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_I    = 2'd1,
        OWNER_D    = 2'd2
    } owner_e;

    // Side of a two-input round-robin that won most recently.
    typedef enum logic {
        SIDE_0 = 1'b0,
        SIDE_1 = 1'b1
    } rr_side_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and single-port RAM signals around the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDRESS_BITS = 16
);
    import mem_arb_pkg::*;

    // Handshake: a request transfers in a cycle where req and ready are both high;
    // the requester holds req/address/wEn/write_data stable until then, and ready
    // depends only on req and arbiter state. rvalid marks read data one cycle later.
    logic                    i_req;
    logic [ADDRESS_BITS-1:0] i_address;
    logic                    i_ready;
    logic                    i_rvalid;
    logic [WORD_BITS-1:0]    i_read_data;

    logic                    d_req;
    logic                    d_wEn;
    logic [ADDRESS_BITS-1:0] d_address;
    logic [WORD_BITS-1:0]    d_write_data;
    logic                    d_ready;
    logic                    d_rvalid;
    logic [WORD_BITS-1:0]    d_read_data;

    logic                    mem_en;
    logic                    mem_wEn;
    logic [ADDRESS_BITS-1:0] mem_address;
    logic [WORD_BITS-1:0]    mem_write_data;
    logic [WORD_BITS-1:0]    mem_read_data;

    modport slave (
        input  i_req, i_address,
        output i_ready, i_rvalid, i_read_data,
        input  d_req, d_wEn, d_address, d_write_data,
        output d_ready, d_rvalid, d_read_data,
        output mem_en, mem_wEn, mem_address, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output i_req, i_address,
        input  i_ready, i_rvalid, i_read_data,
        output d_req, d_wEn, d_address, d_write_data,
        input  d_ready, d_rvalid, d_read_data,
        input  mem_en, mem_wEn, mem_address, mem_write_data,
        output mem_read_data
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter: a lone request wins, a conflict goes to the side
// that did not win last. The last winner only changes on a grant.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output rr_side_e   last_o
);

    rr_side_e last_q;
    rr_side_e last_d;

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[0] && req_i[1]) begin
            if (last_q == SIDE_0) begin
                gnt_o = 2'b10;
            end else begin
                gnt_o = 2'b01;
            end
        end else begin
            gnt_o = req_i;
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_o[0]) begin
            last_d = SIDE_0;
        end else if (gnt_o[1]) begin
            last_d = SIDE_1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= SIDE_0;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (side 0) and
// load/store (side 1), routing each read response back to the requester that issued it.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_BITS = 16
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus,
    output rr_side_e           last_grant_o,
    output owner_e             resp_owner_o
);

    logic [1:0]              req_v;
    logic [1:0]              gnt;
    rr_side_e                last_grant;
    owner_e                  owner_q;
    owner_e                  owner_d;
    logic [ADDRESS_BITS-1:0] addr_sel;

    // Masking requests during reset keeps ready and the RAM strobe low without
    // the round-robin core needing to know about it.
    assign req_v = {bus.d_req, bus.i_req} & {2{~reset}};

    rr_arbiter2 u_rr (
        .clk_i  (clock),
        .rst_i  (reset),
        .req_i  (req_v),
        .gnt_o  (gnt),
        .last_o (last_grant)
    );

    assign bus.i_ready = gnt[0];
    assign bus.d_ready = gnt[1];

    always_comb begin
        bus.mem_en         = 1'b0;
        bus.mem_wEn        = 1'b0;
        bus.mem_write_data = '0;
        addr_sel           = '0;
        if (gnt[0]) begin
            bus.mem_en = 1'b1;
            addr_sel   = bus.i_address;
        end else if (gnt[1]) begin
            bus.mem_en         = 1'b1;
            bus.mem_wEn        = bus.d_wEn;
            addr_sel           = bus.d_address;
            bus.mem_write_data = bus.d_write_data;
        end
    end

    assign bus.mem_address = addr_sel;

    // Writes finish in their grant cycle, so only reads leave a response owner.
    always_comb begin
        owner_d = OWNER_NONE;
        if (gnt[0]) begin
            owner_d = OWNER_I;
        end else if (gnt[1] && !bus.d_wEn) begin
            owner_d = OWNER_D;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q <= OWNER_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // A response still in flight when reset rises is dropped, never shown.
    assign bus.i_rvalid    = (owner_q == OWNER_I) && !reset;
    assign bus.d_rvalid    = (owner_q == OWNER_D) && !reset;
    assign bus.i_read_data = bus.i_rvalid ? bus.mem_read_data : '0;
    assign bus.d_read_data = bus.d_rvalid ? bus.mem_read_data : '0;

    assign last_grant_o = last_grant;
    assign resp_owner_o = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked against
// a transaction-level model of arbitration, RAM contents and one-cycle read latency.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } d_txn_t;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDRESS_BITS(AW)) bus ();
  rr_side_e dbg_last;
  owner_e   dbg_owner;

  mem_port_arbiter #(.ADDRESS_BITS(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .last_grant_o (dbg_last),
    .resp_owner_o (dbg_owner)
  );

  // RAM behaviour: read data appears the cycle after a read strobe, garbage otherwise
  logic [31:0] ram [int];

  function automatic logic [31:0] init_word(logic [AW-1:0] a);
    return 32'hA5A5_0000 ^ ({16'h0, a} * 32'h9E37_79B1);
  endfunction

  always @(posedge clock) begin
    if (bus.mem_en && bus.mem_wEn) begin
      ram[int'(bus.mem_address)] = bus.mem_write_data;
      bus.mem_read_data <= $urandom();
    end else if (bus.mem_en) begin
      bus.mem_read_data <= ram.exists(int'(bus.mem_address)) ?
                           ram[int'(bus.mem_address)] : init_word(bus.mem_address);
    end else begin
      bus.mem_read_data <= $urandom();
    end
  end

  // scoreboard / reference model state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] model_mem [int];
  bit          m_last_d = 1'b0;
  bit          i_pend = 1'b0;
  bit          d_pend = 1'b0;
  bit          i_gnt_m = 1'b0;
  bit          d_gnt_m = 1'b0;
  bit          i_hold = 1'b0;
  bit          d_hold = 1'b0;
  logic [AW-1:0] i_hold_addr;
  d_txn_t      d_hold_txn;
  bit          rand_mode = 1'b0;
  logic [AW-1:0] i_stim_q[$];
  d_txn_t      d_stim_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(logic [AW-1:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : init_word(a);
  endfunction

  // Called at the negedge: inputs are stable, compare outputs against the model
  task automatic check_cycle();
    logic [31:0] exp_data;
    bit gi;
    bit gd;
    if (i_hold)
      assert (bus.i_req && bus.i_address == i_hold_addr)
        else $error("fetch requester let go of its request before ready");
    if (d_hold)
      assert (bus.d_req && bus.d_address == d_hold_txn.addr && bus.d_wEn == d_hold_txn.we
              && bus.d_write_data == d_hold_txn.data)
        else $error("data requester let go of its request before ready");

    chk("i_rvalid", {31'b0, bus.i_rvalid}, {31'b0, i_pend && !reset});
    exp_data = '0;
    if (i_pend) begin
      exp_data = exp_i_q.pop_front();
      if (reset) exp_data = '0;
    end
    chk("i_read_data", bus.i_read_data, exp_data);

    chk("d_rvalid", {31'b0, bus.d_rvalid}, {31'b0, d_pend && !reset});
    exp_data = '0;
    if (d_pend) begin
      exp_data = exp_d_q.pop_front();
      if (reset) exp_data = '0;
    end
    chk("d_read_data", bus.d_read_data, exp_data);

    gi = 1'b0;
    gd = 1'b0;
    if (!reset) begin
      if (bus.i_req && bus.d_req) begin
        if (m_last_d) gi = 1'b1;
        else gd = 1'b1;
      end else begin
        gi = bus.i_req;
        gd = bus.d_req;
      end
    end

    chk("i_ready", {31'b0, bus.i_ready}, {31'b0, gi});
    chk("d_ready", {31'b0, bus.d_ready}, {31'b0, gd});
    chk("mem_en", {31'b0, bus.mem_en}, {31'b0, gi || gd});
    chk("mem_wEn", {31'b0, bus.mem_wEn}, {31'b0, gd && bus.d_wEn});
    chk("mem_address", {16'b0, bus.mem_address},
        {16'b0, gi ? bus.i_address : (gd ? bus.d_address : 16'h0)});
    chk("mem_write_data", bus.mem_write_data, gd ? bus.d_write_data : 32'h0);
    chk("last_grant", {31'b0, dbg_last == SIDE_1}, {31'b0, m_last_d});

    if (reset) begin
      m_last_d = 1'b0;
      i_pend   = 1'b0;
      d_pend   = 1'b0;
      exp_i_q.delete();
      exp_d_q.delete();
    end else begin
      i_pend = gi;
      d_pend = gd && !bus.d_wEn;
      if (gi) begin
        m_last_d = 1'b0;
        exp_i_q.push_back(model_rd(bus.i_address));
      end
      if (gd) begin
        m_last_d = 1'b1;
        if (bus.d_wEn) model_mem[int'(bus.d_address)] = bus.d_write_data;
        else exp_d_q.push_back(model_rd(bus.d_address));
      end
    end
    i_gnt_m     = gi;
    d_gnt_m     = gd;
    i_hold      = bus.i_req && !bus.i_ready;
    i_hold_addr = bus.i_address;
    d_hold      = bus.d_req && !bus.d_ready;
    d_hold_txn  = '{bus.d_wEn, bus.d_address, bus.d_write_data};
  endtask

  // driver: retire transferred requests, then load the next one
  task automatic advance();
    d_txn_t t;
    bit load;
    if (i_gnt_m) bus.i_req = 1'b0;
    if (d_gnt_m) bus.d_req = 1'b0;
    i_gnt_m = 1'b0;
    d_gnt_m = 1'b0;
    if (!bus.i_req) begin
      if (i_stim_q.size() != 0) begin
        bus.i_req     = 1'b1;
        bus.i_address = i_stim_q.pop_front();
      end else if (rand_mode && $urandom_range(0, 2) != 0) begin
        bus.i_req     = 1'b1;
        bus.i_address = AW'($urandom_range(0, 31));
      end
    end
    if (!bus.d_req) begin
      load = 1'b0;
      t    = '0;
      if (d_stim_q.size() != 0) begin
        t    = d_stim_q.pop_front();
        load = 1'b1;
      end else if (rand_mode && $urandom_range(0, 2) != 0) begin
        t.we   = ($urandom_range(0, 2) == 0);
        t.addr = AW'($urandom_range(0, 31));
        t.data = $urandom();
        load   = 1'b1;
      end
      if (load) begin
        bus.d_req        = 1'b1;
        bus.d_wEn        = t.we;
        bus.d_address    = t.addr;
        bus.d_write_data = t.data;
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    #1;
    advance();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bus.i_req || bus.d_req || i_stim_q.size() != 0 || d_stim_q.size() != 0) && n < 50) begin
      step();
      n++;
    end
    chk("drain_within_budget", {31'b0, n < 50}, 32'd1);
  endtask

  initial begin
    // reset held 3 cycles while both requesters ask
    bus.i_req        = 1'b1;
    bus.i_address    = 16'h0200;
    bus.d_req        = 1'b1;
    bus.d_wEn        = 1'b0;
    bus.d_address    = 16'h0300;
    bus.d_write_data = 32'h0;
    repeat (3) step();
    reset = 1'b0;
    step();
    drain();

    // fetch-only stream
    i_stim_q = '{16'h0010, 16'h0014, 16'h0018};
    advance();
    repeat (4) step();
    drain();

    // both requesting continuously
    i_stim_q = '{16'h0020, 16'h0024, 16'h0028};
    d_stim_q = '{'{1'b0, 16'h0030, 32'h0}, '{1'b1, 16'h0034, 32'h1234_5678},
                 '{1'b0, 16'h0034, 32'h0}};
    advance();
    repeat (7) step();
    drain();

    // store then load the same word
    d_stim_q = '{'{1'b1, 16'h0100, 32'hDEAD_BEEF}, '{1'b0, 16'h0100, 32'h0}};
    advance();
    repeat (3) step();
    drain();

    // reset right after a fetch read grant, then after a data read grant
    i_stim_q = '{16'h0044};
    advance();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    d_stim_q = '{'{1'b0, 16'h0048, 32'h0}};
    advance();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    i_stim_q = '{16'h004C};
    d_stim_q = '{'{1'b0, 16'h0050, 32'h0}};
    advance();
    repeat (3) step();
    drain();

    // idle gap, then conflicts resume alternation
    i_stim_q = '{16'h0054};
    advance();
    step();
    repeat (3) step();
    i_stim_q = '{16'h0058, 16'h005C};
    d_stim_q = '{'{1'b0, 16'h0060, 32'h0}, '{1'b0, 16'h0064, 32'h0}};
    advance();
    repeat (5) step();
    drain();

    // random traffic with occasional resets
    rand_mode = 1'b1;
    advance();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset     = 1'b0;
    rand_mode = 1'b0;
    drain();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
